// File: rtl/serial_sub.sv
// Digit-serial subtractor: a - b - bin over WIDTH bits, DIGIT_W bits per clock.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub #(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int K  = WIDTH / DIGIT_W;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               brw_q, brw_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               load_en, shift_en, last_dig;
  logic [DIGIT_W:0]   dig_full;
  logic [DIGIT_W-1:0] dig;
  logic [WIDTH-1:0]   result_full;

  // One extra bit catches the borrow: the sum goes negative exactly when a_digit < b_digit + borrow.
  assign dig_full = {1'b0, a_q[DIGIT_W-1:0]} - {1'b0, b_q[DIGIT_W-1:0]}
                  - {{DIGIT_W{1'b0}}, brw_q};
  assign dig      = dig_full[DIGIT_W-1:0];
  assign last_dig = (cnt_q == CW'(K - 1));

  // Earlier digits live in res_q; the final digit is merged in combinationally on the last edge.
  generate
    if (K > 1) begin : g_res
      logic [WIDTH-DIGIT_W-1:0] res_q, res_d;
      logic [WIDTH-1:0]         res_cat;

      assign res_cat     = {dig, res_q};
      assign result_full = res_cat;

      always_comb begin
        res_d = res_q;
        if (load_en) begin
          res_d = '0;
        end else if (shift_en) begin
          res_d = res_cat[WIDTH-1:DIGIT_W];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) res_q <= '0;
        else        res_q <= res_d;
      end
    end else begin : g_nores
      assign result_full = dig;
    end
  endgenerate

`ifdef SERIAL_SUB_OVF_EN
  logic [1:0] msb_q, msb_d;
  logic       ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    brw_d    = brw_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    load_en  = 1'b0;
    shift_en = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    msb_d    = msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          load_en = 1'b1;
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          msb_d   = {a[WIDTH-1], b[WIDTH-1]};
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        shift_en = 1'b1;
        a_d      = a_q >> DIGIT_W;
        b_d      = b_q >> DIGIT_W;
        brw_d    = dig_full[DIGIT_W];
        cnt_d    = cnt_q + 1'b1;
        if (last_dig) begin
          diff_d  = result_full;
          bout_d  = dig_full[DIGIT_W];
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (msb_q[1] ^ msb_q[0]) & (result_full[WIDTH-1] ^ msb_q[1]);
`endif
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      msb_q   <= '0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      msb_q   <= msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Directed and random checks of serial_sub in two configurations (8/2 and 8/8).
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, bin, busy, done, bout;
  logic [7:0] a, b, diff;
  logic       start_w, bin_w, busy_w, done_w, bout_w;
  logic [7:0] a_w, b_w, diff_w;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf, ovf_w;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  exp_t sb[$];
  exp_t sb_w[$];

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8), .DIGIT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_sub #(.WIDTH(8), .DIGIT_W(8)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .a(a_w), .b(b_w), .bin(bin_w),
    .busy(busy_w), .done(done_w), .diff(diff_w), .bout(bout_w)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf_w)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic bi);
    exp_t e;
    logic [8:0] full;
    full = {1'b0, av} - {1'b0, bv} - {8'd0, bi};
    e.d  = full[7:0];
    e.bo = full[8];
    e.ov = (av[7] ^ bv[7]) & (full[7] ^ av[7]);
    return e;
  endfunction

  // mode 0: plain; 1: start pulsed during RUN; 2: start pulsed during DONE
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic bi, input int mode);
    exp_t e;
    int lat, busy_n;
    @(negedge clk);
    a = av; b = bv; bin = bi; start = 1'b1;
    sb.push_back(model(av, bv, bi));
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    lat = 0; busy_n = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_n++;
      if (mode == 1 && lat == 1) start = 1'b1;
      else if (mode == 1 && lat == 2) start = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 4);
    chk("busy_cycles", busy_n, 4);
    e = model(8'h00, 8'h00, 1'b0);
    if (sb.size() > 0) e = sb.pop_front();
    chk("diff", {24'd0, diff}, {24'd0, e.d});
    chk("bout", {31'd0, bout}, {31'd0, e.bo});
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", {31'd0, ovf}, {31'd0, e.ov});
`endif
    if (mode == 2) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("diff_hold", {24'd0, diff}, {24'd0, e.d});
    if (mode != 0) begin
      chk("busy_after", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("no_reaccept", {31'd0, busy | done}, 32'd0);
    end
    $display("op a=%02h b=%02h bin=%0d mode=%0d -> diff=%02h bout=%0d", av, bv, bi, mode, diff, bout);
  endtask

  task automatic run_wide(input logic [7:0] av, input logic [7:0] bv, input logic bi, input bit verbose);
    exp_t e;
    int lat, busy_n;
    @(negedge clk);
    a_w = av; b_w = bv; bin_w = bi; start_w = 1'b1;
    sb_w.push_back(model(av, bv, bi));
    @(negedge clk);
    start_w = 1'b0;
    lat = 0; busy_n = 0;
    while (done_w !== 1'b1 && lat < 20) begin
      if (busy_w === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
    chk("w_latency", lat, 1);
    chk("w_busy_cycles", busy_n, 1);
    e = model(8'h00, 8'h00, 1'b0);
    if (sb_w.size() > 0) e = sb_w.pop_front();
    chk("w_diff", {24'd0, diff_w}, {24'd0, e.d});
    chk("w_bout", {31'd0, bout_w}, {31'd0, e.bo});
    @(negedge clk);
    chk("w_done_pulse", {31'd0, done_w}, 32'd0);
    if (verbose)
      $display("wide op a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d", av, bv, bi, diff_w, bout_w);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0; a = '0; b = '0; bin = 1'b0;
    start_w = 1'b0; a_w = '0; b_w = '0; bin_w = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {24'd0, diff}, 32'd0);
    chk("rst_bout", {31'd0, bout}, 32'd0);
    chk("rst_w_diff", {24'd0, diff_w}, 32'd0);
    rst_n = 1'b1;

    run_op(8'h05, 8'h03, 1'b0, 0);
    run_op(8'h03, 8'h05, 1'b0, 1);
    run_op(8'h00, 8'h00, 1'b1, 2);
    run_op(8'h80, 8'h01, 1'b0, 0);
    run_op(8'h10, 8'h01, 1'b0, 0);

    // Abort in the second RUN cycle, then check no stale borrow leaks into the next op.
    @(negedge clk);
    a = 8'hAA; b = 8'h55; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_diff", {24'd0, diff}, 32'd0);
    chk("abort_bout", {31'd0, bout}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("abort_ovf", {31'd0, ovf}, 32'd0);
`endif
    $display("reset asserted mid-RUN: busy=%0d diff=%02h", busy, diff);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h09, 8'h04, 1'b0, 0);

    run_wide(8'h00, 8'h01, 1'b0, 1'b1);

    for (int i = 0; i < 400; i++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 0);
    for (int i = 0; i < 600; i++)
      run_wide(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
